pixel_window_3x3: RTL and testbench

//  Consumes the 24-bit pixel stream assembled from SD-card reads by the SPI front end and builds a

---
 rtl/conv_pkg.sv | 15 +
 rtl/pixel_window_3x3_if.sv | 30 +++
 rtl/line_buffer.sv | 26 ++
 rtl/pixel_window_3x3.sv | 133 +++++++++++++
 tb/tb_pixel_window_3x3.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared convolution-path definitions: pixel width, window taps and FSM states.
package conv_pkg;

  localparam int unsigned PIX_W      = 24;
  localparam int unsigned WIN_TAPS   = 9;
  localparam int unsigned WIN_W      = WIN_TAPS * PIX_W;
  localparam int unsigned TAP_CENTRE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in, 3x3 window out; the master drives pixels, the slave builds windows.
interface pixel_window_3x3_if #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
);
  import conv_pkg::*;

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic             frame_start;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic [WIN_W-1:0] win;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             frame_done;

  modport master (
    output frame_start, pix_in, pix_valid,
    input  win, win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  frame_start, pix_in, pix_valid,
    output win, win_valid, win_row, win_col, frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// Single-port row store: asynchronous read, registered write, read sees old contents.
module line_buffer #(
  parameter  int unsigned DEPTH = 640,
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read is combinational so the same-cycle write never shadows the old value.
  assign rd_data_c = mem[addr];

  // Storage is not reset; every location is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_window_3x3.sv
// Sliding 3x3 neighbourhood generator over a raster pixel stream without backpressure.
module pixel_window_3x3
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input logic clk,
  input logic rst_n,
  pixel_window_3x3_if.slave bus
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  fsm_state_e       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic             accept, last_pix, full_win;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic [WIN_W-1:0] win_q;
  logic             win_valid_q;
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;
  logic             frame_done_q;

  // Next-state, counter advance and per-pixel decode.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cur_row  = row_q;
    cur_col  = col_q;
    accept   = 1'b0;
    last_pix = 1'b0;
    full_win = 1'b0;

    if (bus.frame_start) begin
      cur_row = '0;
      cur_col = '0;
      row_d   = '0;
      col_d   = '0;
    end

    accept = bus.pix_valid && (bus.frame_start || (state_q == ACTIVE));

    if (accept) begin
      full_win = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = last_pix ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end

    unique case (state_q)
      IDLE:    if (bus.frame_start) state_d = ACTIVE;
      ACTIVE:  if (last_pix)        state_d = DONE;
      DONE:    if (bus.frame_start) state_d = ACTIVE;
      default:                      state_d = IDLE;
    endcase
  end

  // FSM state and raster position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // lb1 holds the previous row, lb0 the row before it; lb0 is refilled from lb1.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk       (clk),
    .wr_en     (accept),
    .addr      (cur_col),
    .wr_data   (lb1_rd),
    .rd_data_c (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk       (clk),
    .wr_en     (accept),
    .addr      (cur_col),
    .wr_data   (bus.pix_in),
    .rd_data_c (lb1_rd)
  );

  // Window shift (new right column enters top-to-bottom) and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= full_win;
      frame_done_q <= last_pix;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 2; c++) begin
            win_q[(r*3+c)*PIX_W +: PIX_W] <= win_q[(r*3+c+1)*PIX_W +: PIX_W];
          end
        end
        win_q[2*PIX_W +: PIX_W] <= lb0_rd;
        win_q[5*PIX_W +: PIX_W] <= lb1_rd;
        win_q[8*PIX_W +: PIX_W] <= bus.pix_in;
      end
      if (full_win) begin
        win_row_q <= cur_row - ROW_W'(1);
        win_col_q <= cur_col - COL_W'(1);
      end
    end
  end

  assign bus.win        = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Scoreboard bench for pixel_window_3x3 on a 4x4 image.
module tb_pixel_window_3x3;
  import conv_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  typedef struct {
    logic [WIN_W-1:0] w;
    logic [1:0]       r;
    logic [1:0]       c;
  } exp_t;

  logic clk;
  logic rst_n;

  pixel_window_3x3_if #(.IMG_W(W), .IMG_H(H)) bus ();

  pixel_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t             sb[$];
  logic [PIX_W-1:0] img [H][W];
  int               m_state = 0;
  int               m_row   = 0;
  int               m_col   = 0;
  bit               exp_valid = 1'b0;
  bit               exp_fd    = 1'b0;
  bit               exp_moved = 1'b0;
  logic [WIN_W-1:0] last_win  = '0;
  logic [WIN_W-1:0] first_win = '0;
  logic [1:0]       first_row = '0;
  logic [1:0]       first_col = '0;
  int               win_cnt = 0;
  int               fd_cnt  = 0;

  task automatic expect_eq(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare the outputs registered on the previous edge against the model.
  task automatic sample();
    exp_t e;
    expect_eq("win_valid", WIN_W'(bus.win_valid), WIN_W'(exp_valid));
    expect_eq("frame_done", WIN_W'(bus.frame_done), WIN_W'(exp_fd));
    if (!exp_moved) expect_eq("win_hold", bus.win, last_win);
    if (bus.win_valid) begin
      if (sb.size() == 0) begin
        expect_eq("sb_depth", WIN_W'(sb.size()), WIN_W'(1));
      end else begin
        e = sb.pop_front();
        expect_eq("win", bus.win, e.w);
        expect_eq("win_row", WIN_W'(bus.win_row), WIN_W'(e.r));
        expect_eq("win_col", WIN_W'(bus.win_col), WIN_W'(e.c));
      end
      if (win_cnt == 0) begin
        first_win = bus.win;
        first_row = bus.win_row;
        first_col = bus.win_col;
      end
      win_cnt++;
    end
    if (bus.frame_done) fd_cnt++;
    last_win = bus.win;
  endtask

  // Behavioural image model: stores pixels by position and cuts windows from it.
  task automatic model_update(input bit fs, input bit pv, input logic [PIX_W-1:0] val);
    bit   acc;
    exp_t e;
    int   r;
    int   c;
    if (fs) begin
      m_row = 0;
      m_col = 0;
    end
    acc       = pv && (fs || m_state == 1);
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_moved = acc;
    if (acc) begin
      r = m_row;
      c = m_col;
      img[r][c] = val;
      if (r >= 2 && c >= 2) begin
        e.w = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            e.w[(dr*3+dc)*PIX_W +: PIX_W] = img[r-2+dr][c-2+dc];
        e.r = 2'(r - 1);
        e.c = 2'(c - 1);
        sb.push_back(e);
        exp_valid = 1'b1;
      end
      if (r == H - 1 && c == W - 1) begin
        exp_fd  = 1'b1;
        m_state = 2;
        m_row   = 0;
        m_col   = 0;
      end else begin
        if (c == W - 1) begin
          m_col = 0;
          m_row = m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
        if (fs) m_state = 1;
      end
    end else if (fs) begin
      m_state = 1;
    end
  endtask

  task automatic step(input bit fs, input bit pv, input logic [PIX_W-1:0] val);
    @(negedge clk);
    sample();
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_in      = val;
    model_update(fs, pv, val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic drive_frame(input int base, input int max_gap, input bit fs_same);
    int g;
    if (!fs_same) step(1'b1, 1'b0, '0);
    for (int i = 0; i < int'(W * H); i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (i > 0) begin
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, PIX_W'($urandom));
      end
      step(fs_same && (i == 0), 1'b1, PIX_W'(base + i));
    end
  endtask

  task automatic check_counts(input string tag, input int wins, input int fds);
    expect_eq({tag, "_wins"}, WIN_W'(win_cnt), WIN_W'(wins));
    expect_eq({tag, "_done"}, WIN_W'(fd_cnt), WIN_W'(fds));
    win_cnt = 0;
    fd_cnt  = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    expect_eq({tag, "_win"}, bus.win, '0);
    expect_eq({tag, "_valid"}, WIN_W'(bus.win_valid), '0);
    expect_eq({tag, "_row"}, WIN_W'(bus.win_row), '0);
    expect_eq({tag, "_col"}, WIN_W'(bus.win_col), '0);
    expect_eq({tag, "_done"}, WIN_W'(bus.frame_done), '0);
  endtask

  initial begin
    logic [WIN_W-1:0] ref_win;
    int               ref_idx [9];

    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_in      = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back frame
    drive_frame(0, 0, 1'b0);
    idle(2);
    ref_idx = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    ref_win = '0;
    for (int t = 0; t < 9; t++) ref_win[t*PIX_W +: PIX_W] = PIX_W'(ref_idx[t]);
    expect_eq("first_win", first_win, ref_win);
    expect_eq("first_centre", WIN_W'(first_win[TAP_CENTRE*PIX_W +: PIX_W]), WIN_W'(5));
    expect_eq("first_row", WIN_W'(first_row), WIN_W'(1));
    expect_eq("first_col", WIN_W'(first_col), WIN_W'(1));
    check_counts("s1", 4, 1);

    // 2: same frame with random gaps
    drive_frame(0, 5, 1'b0);
    idle(2);
    check_counts("s2", 4, 1);

    // 3: restart mid-frame with frame_start and pix_valid together
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PIX_W'(i));
    drive_frame(100, 0, 1'b1);
    idle(2);
    check_counts("s3", 4, 1);

    // 4: asynchronous reset after pixel 9
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, PIX_W'(i));
    idle(1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    sb.delete();
    m_state = 0; m_row = 0; m_col = 0;
    exp_valid = 1'b0; exp_fd = 1'b0; exp_moved = 1'b0;
    last_win = '0;
    win_cnt = 0; fd_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PIX_W'(50 + i));
    idle(1);
    drive_frame(0, 0, 1'b0);
    idle(2);
    check_counts("s4", 4, 1);

    // 5: extra pixels past frame end
    drive_frame(0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, PIX_W'(16 + i));
    idle(2);
    check_counts("s5", 4, 1);

    // 6: two frames with different data
    drive_frame(1000, 0, 1'b0);
    drive_frame(2000, 2, 1'b0);
    idle(2);
    check_counts("s6", 8, 2);

    expect_eq("sb_left", WIN_W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
